// File: rtl/prog_ram_pkg.sv
// Shared definitions for the program RAM loader: default geometry and the
// loader FSM state encoding.
package prog_ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prog_ram_mem.sv
// Program RAM storage: one write port, one registered read port.
// The read samples the array before this cycle's write lands, so a
// same-address write/read returns the old word (read-before-write).
// The whole array clears on reset, so it is built from flops, not a RAM macro.
module prog_ram_mem
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage write port and registered read; reset wipes every word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
      if (i_we) r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_ram_loader.sv
// Program RAM loader: a start pulse opens a pass that accepts exactly DEPTH
// words on a valid/ready stream into consecutive addresses, then parks in
// DONE until the next start. Memory is readable at any time with 1-cycle
// latency.
// Optional feature: define PROG_RAM_CHECKSUM_EN to add a running modular
// sum of the words accepted in the current pass (port checksum).
module prog_ram_loader
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
`ifdef PROG_RAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_xfer;
  logic              w_last;
  logic              w_new_pass;

  // A transfer only happens while ready is up, i.e. in LOAD.
  assign w_xfer     = wr_valid && wr_ready;
  assign w_last     = (r_ptr == ADDR_W'(DEPTH - 1));
  // Start is honoured from IDLE and DONE only; mid-pass pulses are dropped.
  assign w_new_pass = start && (r_state != LOAD);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (w_xfer && w_last) w_next = DONE;
      DONE:    if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  // FSM Moore outputs; all low in IDLE, which also covers reset.
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      LOAD:    begin wr_ready = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Write pointer and accepted-word count; pointer holds on the last word
  // instead of wrapping so a pass never overwrites address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_new_pass) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + (ADDR_W + 1)'(1);
      if (!w_last) r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  assign wr_count = r_count;

`ifdef PROG_RAM_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  // Running sum of accepted words, restarted with each pass.
  always_ff @(posedge clk) begin
    if (!rst_n)          r_sum <= '0;
    else if (w_new_pass) r_sum <= '0;
    else if (w_xfer)     r_sum <= r_sum + wr_data;
  end

  assign checksum = r_sum;
`endif

  prog_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_xfer),
    .i_waddr (r_ptr),
    .i_wdata (wr_data),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader with a per-cycle reference model and a
// read-data scoreboard queue, plus directed constant checks at key points.
module tb_prog_ram_loader;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, wr_valid;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic          wr_ready, busy, done;
  logic [DW-1:0] rd_data;
  logic [AW:0]   wr_count;
`ifdef PROG_RAM_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  prog_ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count)
`ifdef PROG_RAM_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model state: 0=IDLE 1=LOAD 2=DONE.
  logic [DW-1:0] model [DEPTH];
  int            m_st, m_ptr, m_cnt;
  logic [DW-1:0] m_sum;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the inputs now driven, clock, then compare.
  task automatic cyc();
    logic [DW-1:0] exp_rd;
    exp_rd = rst_n ? model[rd_addr] : '0;
    sb.push_back(exp_rd);
    if (!rst_n) begin
      m_st = 0; m_ptr = 0; m_cnt = 0; m_sum = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else begin
      case (m_st)
        1: if (wr_valid) begin
             model[m_ptr] = wr_data;
             m_sum = m_sum + wr_data;
             m_cnt++;
             if (m_ptr == DEPTH - 1) m_st = 2;
             else m_ptr++;
           end
        default: if (start) begin
             m_st = 1; m_ptr = 0; m_cnt = 0; m_sum = '0;
           end
      endcase
    end
    @(posedge clk); #1;
    chk("rd_data", rd_data, sb.pop_front());
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("wr_ready", wr_ready, m_st == 1);
    chk("wr_count", wr_count, m_cnt);
`ifdef PROG_RAM_CHECKSUM_EN
    chk("checksum", checksum, m_sum);
`endif
  endtask

  task automatic xfer(input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_data = d; cyc(); wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic sweep_const(input string tag, input logic [DW-1:0] v);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); cyc(); chk(tag, rd_data, v);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    m_st = 0; m_ptr = 0; m_cnt = 0; m_sum = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset, then wr_valid in IDLE must be ignored.
    repeat (2) cyc();
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_data = 16'hBEEF; cyc(); cyc(); wr_valid = 1'b0;
    sweep_const("rst_sweep", 16'h0000);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", wr_ready, 0);
    chk("idle_count", wr_count, 0);

    // Back-to-back load of 1..16.
    pulse_start();
    chk("load_busy", busy, 1);
    chk("load_ready", wr_ready, 1);
    for (int i = 0; i < DEPTH; i++) xfer(DW'(i + 1));
    chk("b2b_done", done, 1);
    chk("b2b_busy", busy, 0);
    chk("b2b_count", wr_count, 16);
`ifdef PROG_RAM_CHECKSUM_EN
    chk("b2b_checksum", checksum, 136);
`endif
    rd_addr = 4'd9; cyc(); chk("b2b_addr9", rd_data, 10);

    // wr_valid in DONE must be ignored.
    wr_valid = 1'b1; wr_data = 16'hDEAD; rd_addr = 4'd0; cyc(); cyc(); wr_valid = 1'b0;
    chk("done_hold_count", wr_count, 16);
    rd_addr = 4'd0; cyc(); chk("done_addr0", rd_data, 1);

    // Valid toggling every other cycle; gaps must not advance.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      xfer(DW'(16'h0100 + i));
      wr_data = 16'hFFFF; cyc();
      if (i < DEPTH - 1) chk("gap_count", wr_count, i + 1);
    end
    chk("tog_done", done, 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); cyc(); chk("tog_order", rd_data, 16'h0100 + a);
    end

    // Start at wr_count=5 is ignored.
    pulse_start();
    for (int i = 0; i < 5; i++) xfer(DW'(16'h0200 + i));
    chk("pre_restart_count", wr_count, 5);
    pulse_start();
    chk("restart_ign_count", wr_count, 5);
    chk("restart_ign_busy", busy, 1);
    for (int i = 5; i < DEPTH; i++) xfer(DW'(16'h0200 + i));
    chk("restart_done", done, 1);
    rd_addr = 4'd5; cyc(); chk("restart_addr5", rd_data, 16'h0205);
    rd_addr = 4'd0; cyc(); chk("restart_addr0", rd_data, 16'h0200);

    // Reset at wr_count=7 with a transfer offered in the same cycle.
    pulse_start();
    for (int i = 0; i < 7; i++) xfer(DW'(16'h0300 + i));
    chk("pre_rst_count", wr_count, 7);
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 16'h3333; cyc();
    rst_n = 1'b1; wr_valid = 1'b0;
    chk("rst7_busy", busy, 0);
    chk("rst7_count", wr_count, 0);
    chk("rst7_ready", wr_ready, 0);
    sweep_const("rst7_zero", 16'h0000);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) xfer(16'hA5A5);
    sweep_const("a5_sweep", 16'hA5A5);

    // Read-before-write at address 3.
    pulse_start();
    for (int i = 0; i < 3; i++) xfer(DW'(16'h3000 + i));
    rd_addr = 4'd3; wr_valid = 1'b1; wr_data = 16'h7777; cyc(); wr_valid = 1'b0;
    chk("rbw_old", rd_data, 16'hA5A5);
    cyc();
    chk("rbw_new", rd_data, 16'h7777);
    for (int i = 4; i < DEPTH; i++) xfer(DW'(16'h3000 + i));
    chk("rbw_done", done, 1);
    chk("rbw_count", wr_count, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_ram_loader.md
PROG_RAM_LOADER -- requirements
Module: prog_ram_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each stored word.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W = 16 words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load pass.
REQ-006 SHALL have port wr_valid, input, 1 bit: the upstream word on wr_data is valid.
REQ-007 SHALL have port wr_data, input, DATA_W bits: the word to store.
REQ-008 SHALL have port wr_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 SHALL have port rd_addr, input, ADDR_W bits: the read address.
REQ-010 SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-011 SHALL have port busy, output, 1 bit: a load pass is in progress.
REQ-012 SHALL have port done, output, 1 bit: all DEPTH words have been loaded.
REQ-013 SHALL have port wr_count, output, ADDR_W+1 bits: the number of words accepted in the current pass.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, LOAD, DONE.
REQ-015 SHALL transition from IDLE to LOAD on start=1, clearing the write pointer and wr_count to 0.
REQ-016 SHALL drive wr_ready=1 only in LOAD; wr_ready is a Moore output and does not depend on wr_valid.
REQ-017 SHALL define a transfer as wr_valid && wr_ready at a rising edge; on each transfer, mem[ptr] is written with wr_data, and ptr and wr_count each increment by 1.
REQ-018 SHALL, on the transfer at ptr=DEPTH-1, write the word, set wr_count=DEPTH, and move to DONE; the pointer SHALL NOT wrap within a pass.
REQ-019 SHALL ignore start while in LOAD (no restart, pointer unchanged).
REQ-020 SHALL hold done=1 continuously in DONE; start in DONE re-enters LOAD with ptr and wr_count cleared to 0, and memory is not cleared.
REQ-021 SHALL drive busy=1 exactly in LOAD.
REQ-022 SHALL assign rd_data <= mem[rd_addr] every cycle in all states (1-cycle latency).
REQ-023 SHALL, when the same address is written and read in the same cycle, return the old contents (read-before-write); the new word SHALL appear on the following read.
REQ-024 SHALL accept no transfer in IDLE or DONE, because wr_ready=0; wr_valid is ignored there.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear ptr, wr_count, rd_data, busy, done, wr_ready and all DEPTH memory words to 0.
REQ-026 SHALL give reset priority over start and over any transfer; reset mid-LOAD abandons the pass, and no partial write from that cycle persists.

Configuration
REQ-027 SHALL, when PROG_RAM_CHECKSUM_EN is defined, add output checksum[DATA_W-1:0], which is cleared to 0 on reset and on entry to LOAD and adds wr_data (mod 2**DATA_W) on each transfer.
REQ-028 SHALL, when PROG_RAM_CHECKSUM_EN is undefined, omit the checksum port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place DATA_W, ADDR_W and DEPTH defaults and the state enum (IDLE/LOAD/DONE) in the shared package prog_ram_pkg.
REQ-030 SHALL place the storage array, its write port and its registered read port in the sub-module prog_ram_mem; the FSM, pointer and checksum reside in prog_ram_loader.

Verification
REQ-031 SHALL cover reset then rd_addr sweep 0..15: rd_data=0 at every address; busy=done=wr_ready=0.
REQ-032 SHALL cover start, then 16 back-to-back transfers of data 1..16: done=1 on the cycle after the 16th transfer, wr_count=16, reading address 9 returns 10, and checksum=136 when PROG_RAM_CHECKSUM_EN is defined.
REQ-033 SHALL cover wr_valid toggled every other cycle during LOAD: exactly 16 words stored in order, and idle cycles do not advance ptr.
REQ-034 SHALL cover a start pulse at wr_count=5 during LOAD: ignored, and the next word lands at address 5.
REQ-035 SHALL cover rst_n=0 at wr_count=7: state returns to IDLE with all memory 0; a new start and 16 words of 0xA5A5 then read back 0xA5A5 everywhere.
REQ-036 SHALL cover a write to address 3 with rd_addr=3 in the same cycle: the old value is returned, and the new value appears one cycle later.
